// File: rtl/pito_hart_scheduler.sv
// Barrel-hart issue scheduler: per-hart OFF/RUN/HALTED FSMs plus a registered round-robin issue offer.
// Optional per-hart transfer counters (perf_sel/perf_count) when PITO_SCHED_PERF_EN is defined.
module pito_hart_scheduler #(
  parameter int NUM_HARTS = 8,
  parameter int HART_ID_W = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic [NUM_HARTS-1:0] hart_block,
  input  logic                 halt_req,
  input  logic [HART_ID_W-1:0] halt_hart,
  input  logic                 issue_ready,
`ifdef PITO_SCHED_PERF_EN
  input  logic [HART_ID_W-1:0] perf_sel,
  output logic [31:0]          perf_count,
`endif
  output logic                 issue_valid,
  output logic [HART_ID_W-1:0] issue_hart,
  output logic [NUM_HARTS-1:0] hart_running,
  output logic                 idle
);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } hart_state_e;

  hart_state_e          r_state     [NUM_HARTS];
  hart_state_e          w_state_nxt [NUM_HARTS];
  logic [NUM_HARTS-1:0] w_running;
  logic [NUM_HARTS-1:0] w_elig;

  logic                 r_issue_valid;
  logic [HART_ID_W-1:0] r_issue_hart;
  logic [HART_ID_W-1:0] r_last_issued;
  logic                 w_issue_valid_nxt;
  logic [HART_ID_W-1:0] w_issue_hart_nxt;
  logic [HART_ID_W-1:0] w_last_nxt;
  logic                 w_xfer;
  logic                 w_hold;
  logic [HART_ID_W-1:0] w_base;
  logic [HART_ID_W-1:0] w_idx;
  logic [HART_ID_W-1:0] w_pick;
  logic                 w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_HARTS; i++) r_state[i] <= S_OFF;
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Disable wins over halt; HALTED only leaves through OFF, so re-entry needs an enable low cycle.
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_OFF: begin
          if (hart_en[i]) w_state_nxt[i] = S_RUN;
        end
        S_RUN: begin
          if (!hart_en[i])                                       w_state_nxt[i] = S_OFF;
          else if (halt_req && (halt_hart == HART_ID_W'(i)))     w_state_nxt[i] = S_HALTED;
        end
        S_HALTED: begin
          if (!hart_en[i]) w_state_nxt[i] = S_OFF;
        end
        default: w_state_nxt[i] = S_OFF;
      endcase
    end
  end

  // A hart leaving RUN this cycle is never offered a fresh slot it could not use.
  always_comb begin
    w_running = '0;
    w_elig    = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      w_running[i] = (r_state[i] == S_RUN);
      w_elig[i]    = (r_state[i] == S_RUN) && !hart_block[i] && (w_state_nxt[i] == S_RUN);
    end
  end

  always_comb begin
    w_xfer  = r_issue_valid && issue_ready;
    w_hold  = r_issue_valid && !issue_ready;
    w_base  = w_xfer ? r_issue_hart : r_last_issued;
    w_found = 1'b0;
    w_pick  = r_issue_hart;
    w_idx   = w_base;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      w_idx = w_base + HART_ID_W'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_last_nxt        = w_base;
    w_issue_hart_nxt  = r_issue_hart;
    w_issue_valid_nxt = 1'b0;
    if (w_hold) begin
      w_issue_valid_nxt = (w_state_nxt[r_issue_hart] == S_RUN);
    end else begin
      w_issue_valid_nxt = w_found;
      if (w_found) w_issue_hart_nxt = w_pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_valid <= 1'b0;
      r_issue_hart  <= '0;
      r_last_issued <= HART_ID_W'(NUM_HARTS - 1);
    end else begin
      r_issue_valid <= w_issue_valid_nxt;
      r_issue_hart  <= w_issue_hart_nxt;
      r_last_issued <= w_last_nxt;
    end
  end

  assign issue_valid  = r_issue_valid;
  assign issue_hart   = r_issue_hart;
  assign hart_running = w_running;
  assign idle         = ~|w_running;

`ifdef PITO_SCHED_PERF_EN
  logic [31:0] r_perf_cnt [NUM_HARTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_HARTS; i++) r_perf_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        if ((r_state[i] == S_OFF) && (w_state_nxt[i] == S_RUN))
          r_perf_cnt[i] <= '0;
        else if (w_xfer && (r_issue_hart == HART_ID_W'(i)))
          r_perf_cnt[i] <= r_perf_cnt[i] + 32'd1;
      end
    end
  end

  assign perf_count = r_perf_cnt[perf_sel];
`endif

endmodule

// File: tb/tb_pito_hart_scheduler.sv
// Randomized and directed bench for pito_hart_scheduler against a behavioural model.
module tb_pito_hart_scheduler;
  localparam int N = 8;
  localparam int M_OFF = 0, M_RUN = 1, M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] hart_en = '0;
  logic [7:0] hart_block = '0;
  logic       halt_req = 1'b0;
  logic [2:0] halt_hart = '0;
  logic       issue_ready = 1'b0;
  logic       issue_valid;
  logic [2:0] issue_hart;
  logic [7:0] hart_running;
  logic       idle;
`ifdef PITO_SCHED_PERF_EN
  logic [2:0]  perf_sel = '0;
  logic [31:0] perf_count;
`endif

  always #5 clk = ~clk;

  pito_hart_scheduler #(.NUM_HARTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .hart_en(hart_en), .hart_block(hart_block),
    .halt_req(halt_req), .halt_hart(halt_hart), .issue_ready(issue_ready),
`ifdef PITO_SCHED_PERF_EN
    .perf_sel(perf_sel), .perf_count(perf_count),
`endif
    .issue_valid(issue_valid), .issue_hart(issue_hart),
    .hart_running(hart_running), .idle(idle)
  );

  int n_pass = 0;
  int n_total = 0;

  int          m_state [N];
  bit          m_valid;
  int          m_hart;
  int          m_last;
  int unsigned m_cnt [N];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_state[i] = M_OFF; m_cnt[i] = 0; end
    m_valid = 0; m_hart = 0; m_last = N - 1;
  endfunction

  function automatic bit [7:0] model_running();
    bit [7:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (m_state[i] == M_RUN);
    return r;
  endfunction

  // One clock of the scheduling rules, applied to the inputs currently driven.
  function automatic void model_step();
    int ns [N];
    bit xfer, found;
    int base;
    for (int i = 0; i < N; i++) begin
      ns[i] = m_state[i];
      if (!hart_en[i]) ns[i] = M_OFF;
      else if (m_state[i] == M_OFF) ns[i] = M_RUN;
      else if (m_state[i] == M_RUN && halt_req && int'(halt_hart) == i) ns[i] = M_HALT;
    end
    xfer = m_valid && issue_ready;
    if (xfer) m_cnt[m_hart] = m_cnt[m_hart] + 1;
    for (int i = 0; i < N; i++)
      if (m_state[i] == M_OFF && ns[i] == M_RUN) m_cnt[i] = 0;
    if (m_valid && !issue_ready) begin
      if (ns[m_hart] != M_RUN) m_valid = 0;
    end else begin
      base   = xfer ? m_hart : m_last;
      m_last = base;
      found  = 0;
      for (int k = 1; k <= N; k++) begin
        int j = (base + k) % N;
        if (!found && m_state[j] == M_RUN && !hart_block[j] && ns[j] == M_RUN) begin
          found = 1; m_hart = j;
        end
      end
      m_valid = found;
    end
    for (int i = 0; i < N; i++) m_state[i] = ns[i];
  endfunction

  task automatic tick();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hart_en = '0; hart_block = '0; halt_req = 1'b0; halt_hart = '0; issue_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hart_en = 8'hFF; issue_ready = 1'b1;
    model_reset();
    repeat (2) tick();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", issue_valid); else n_pass++;
    n_total++; if (issue_hart !== 3'd0) $display("FAIL reset_hart got %0d want 0", issue_hart); else n_pass++;
    n_total++; if (hart_running !== 8'h00) $display("FAIL reset_running got %h want 00", hart_running); else n_pass++;
    n_total++; if (idle !== 1'b1) $display("FAIL reset_idle got %0b want 1", idle); else n_pass++;
  endtask

  task automatic test_rotation();
    do_reset();
    hart_en = 8'hFF; issue_ready = 1'b1;
    tick();
    n_total++; if (issue_valid !== 1'b0 || hart_running !== 8'hFF)
      $display("FAIL rot_first_edge got valid=%0b run=%h want 0/ff", issue_valid, hart_running); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_total++; if (issue_valid !== 1'b1 || issue_hart !== 3'(c % 8))
        $display("FAIL rot_seq[%0d] got valid=%0b hart=%0d want 1/%0d", c, issue_valid, issue_hart, c % 8); else n_pass++;
    end
  endtask

  task automatic test_block_skip();
    int prev = -1;
    int seen = 0;
    do_reset();
    hart_en = 8'hFF; issue_ready = 1'b1;
    repeat (3) tick();
    hart_block = 8'h04;
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      n_total++; if (issue_valid !== 1'b1 || issue_hart === 3'd2 || (prev == 1 && issue_hart !== 3'd3))
        $display("FAIL block_skip[%0d] got valid=%0b hart=%0d prev=%0d", c, issue_valid, issue_hart, prev); else n_pass++;
      prev = int'(issue_hart);
    end
    hart_block = 8'h00;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (issue_valid && issue_hart == 3'd2) seen = 1;
    end
    n_total++; if (!seen) $display("FAIL block_return got no hart 2 want hart 2 within 8 slots"); else n_pass++;
  endtask

  task automatic test_hold();
    int guard = 0;
    do_reset();
    hart_en = 8'hFF; issue_ready = 1'b1;
    tick();
    while (!(issue_valid && issue_hart == 3'd4) && guard < 20) begin tick(); guard++; end
    n_total++; if (guard >= 20) $display("FAIL hold_reach got no hart 4 offer want hart 4"); else n_pass++;
    tick();
    issue_ready = 1'b0; hart_block = 8'h20;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_total++; if (issue_valid !== 1'b1 || issue_hart !== 3'd5)
        $display("FAIL hold_stable[%0d] got valid=%0b hart=%0d want 1/5", c, issue_valid, issue_hart); else n_pass++;
    end
    issue_ready = 1'b1; hart_block = 8'h00;
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_hart !== 3'd6)
      $display("FAIL hold_release got valid=%0b hart=%0d want 1/6", issue_valid, issue_hart); else n_pass++;
  endtask

  task automatic test_halt();
    int guard = 0;
    do_reset();
    hart_en = 8'hFF; issue_ready = 1'b1;
    tick();
    while (!(issue_valid && issue_hart == 3'd2) && guard < 20) begin tick(); guard++; end
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_hart !== 3'd3)
      $display("FAIL halt_offer got valid=%0b hart=%0d want 1/3", issue_valid, issue_hart); else n_pass++;
    issue_ready = 1'b0; halt_req = 1'b1; halt_hart = 3'd3;
    tick();
    halt_req = 1'b0;
    n_total++; if (issue_valid !== 1'b0 || hart_running[3] !== 1'b0)
      $display("FAIL halt_retract got valid=%0b run3=%0b want 0/0", issue_valid, hart_running[3]); else n_pass++;
    issue_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_total++; if (hart_running[3] !== 1'b0 || (issue_valid && issue_hart == 3'd3))
        $display("FAIL halt_stays[%0d] got run3=%0b hart=%0d want 0/not3", c, hart_running[3], issue_hart); else n_pass++;
    end
    hart_en = 8'hF7;
    tick();
    hart_en = 8'hFF;
    tick();
    n_total++; if (hart_running[3] !== 1'b1) $display("FAIL halt_reenable got run3=%0b want 1", hart_running[3]); else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    hart_en = 8'h80; issue_ready = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 6; c++) begin
      tick();
      n_total++; if (issue_valid !== 1'b1 || issue_hart !== 3'd7)
        $display("FAIL single[%0d] got valid=%0b hart=%0d want 1/7", c, issue_valid, issue_hart); else n_pass++;
    end
    hart_en = 8'h00;
    tick();
    n_total++; if (issue_valid !== 1'b0 || idle !== 1'b1)
      $display("FAIL single_off got valid=%0b idle=%0b want 0/1", issue_valid, idle); else n_pass++;
  endtask

  task automatic test_midreset();
    do_reset();
    hart_en = 8'hFF; issue_ready = 1'b0;
    repeat (2) tick();
    n_total++; if (issue_valid !== 1'b1 || issue_hart !== 3'd0)
      $display("FAIL midrst_pending got valid=%0b hart=%0d want 1/0", issue_valid, issue_hart); else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (issue_valid !== 1'b0 || issue_hart !== 3'd0 || idle !== 1'b1 || hart_running !== 8'h00)
      $display("FAIL midrst_async got valid=%0b hart=%0d idle=%0b run=%h want 0/0/1/00",
               issue_valid, issue_hart, idle, hart_running); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (issue_valid !== 1'b0 || idle !== 1'b1)
      $display("FAIL midrst_release got valid=%0b idle=%0b want 0/1", issue_valid, idle); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b0 || hart_running !== 8'hFF)
      $display("FAIL midrst_edge1 got valid=%0b run=%h want 0/ff", issue_valid, hart_running); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_hart !== 3'd0)
      $display("FAIL midrst_edge2 got valid=%0b hart=%0d want 1/0", issue_valid, issue_hart); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    hart_en = 8'($urandom);
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) hart_en[i] = ~hart_en[i];
      hart_block  = 8'($urandom & $urandom);
      halt_req    = ($urandom_range(0, 3) == 0);
      halt_hart   = 3'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 9) < 7);
      tick();
      n_total++; if (issue_valid !== m_valid || hart_running !== model_running() || idle !== (model_running() == 8'h00))
        $display("FAIL rand_state[%0d] got valid=%0b run=%h idle=%0b want %0b/%h/%0b", c, issue_valid,
                 hart_running, idle, m_valid, model_running(), model_running() == 8'h00); else n_pass++;
      if (m_valid) begin
        n_total++; if (issue_hart !== 3'(m_hart))
          $display("FAIL rand_hart[%0d] got %0d want %0d", c, issue_hart, m_hart); else n_pass++;
      end
`ifdef PITO_SCHED_PERF_EN
      perf_sel = 3'($urandom_range(0, 7));
      #1;
      n_total++; if (perf_count !== m_cnt[perf_sel])
        $display("FAIL rand_perf[%0d] got %0d want %0d", c, perf_count, m_cnt[perf_sel]); else n_pass++;
`endif
    end
  endtask

`ifdef PITO_SCHED_PERF_EN
  task automatic test_perf();
    int xfers = 0;
    int guard = 0;
    int sum = 0;
    do_reset();
    hart_en = 8'hFF; issue_ready = 1'b1;
    while (xfers < 100 && guard < 400) begin
      if (issue_valid) xfers++;
      tick();
      guard++;
    end
    issue_ready = 1'b0;
    n_total++; if (xfers != 100) $display("FAIL perf_xfers got %0d want 100", xfers); else n_pass++;
    for (int i = 0; i < N; i++) begin
      perf_sel = 3'(i);
      #1;
      sum += int'(perf_count);
      n_total++; if (perf_count < 12 || perf_count > 13)
        $display("FAIL perf_hart[%0d] got %0d want 12 or 13", i, perf_count); else n_pass++;
    end
    n_total++; if (sum != 100) $display("FAIL perf_sum got %0d want 100", sum); else n_pass++;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      perf_sel = 3'(i);
      #1;
      n_total++; if (perf_count !== 32'd0) $display("FAIL perf_reset[%0d] got %0d want 0", i, perf_count); else n_pass++;
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_block_skip();
    test_hold();
    test_halt();
    test_single();
    test_midreset();
    test_random();
`ifdef PITO_SCHED_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
